reg_input_window: RTL and testbench

Parametrised multi-line input buffer for the interpolation datapath. It accepts one line of packed integer pixel samples per handshake and keeps the most recent DEPTH lines as a sliding vertical window. It presents that window to the interpolation core with valid/ready flow control and optional top-edge line replication. It sits between the pixel input stage and the interpolation filter.

---
 rtl/reg_input_window_pkg.sv | 23 ++
 rtl/reg_line_slot.sv | 35 +++
 rtl/reg_input_window.sv | 110 +++++++++++
 tb/tb_reg_input_window.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_input_window_pkg.sv
// Shared constants and helpers for the reg_input_window line buffer.
//   PIX_W_DEF / PIXELS_DEF / DEPTH_DEF / PAD_TOP_DEF : default geometry
//   line_width() : packed width of one line (pixels * bits per pixel)
//   slot_lsb()   : LSB position of a window slot inside the packed DATA_OUT bus
package reg_input_window_pkg;

  localparam int unsigned PIX_W_DEF   = 8;
  localparam int unsigned PIXELS_DEF  = 9;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned PAD_TOP_DEF = 1;

  function automatic int unsigned line_width(input int unsigned pix_w,
                                             input int unsigned pixels);
    return pix_w * pixels;
  endfunction

  // Slot 0 (oldest line) sits at the LSBs of the window bus.
  function automatic int unsigned slot_lsb(input int unsigned slot,
                                           input int unsigned line_w);
    return slot * line_w;
  endfunction

endpackage

// File: rtl/reg_line_slot.sv
// One line register of the window: LINE_W-bit enable register.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous reset, active low (clears contents)
//   clear_i : synchronous clear, wins over en_i
//   en_i    : load d_i on this edge
//   d_i     : line to load
//   q_o     : stored line
module reg_line_slot
  import reg_input_window_pkg::*;
#(
  parameter int unsigned LINE_W = line_width(PIX_W_DEF, PIXELS_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [LINE_W-1:0] d_i,
  output logic [LINE_W-1:0] q_o
);

  logic [LINE_W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (clear_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_input_window.sv
// Sliding vertical window of the last DEPTH input lines for the interpolator.
//   CLK, RST_ASYNC_N : clock (rising edge), async active-low reset
//   CLEAR            : synchronous flush, overrides all traffic
//   IN_VALID/IN_READY/IN_FIRST/DATA_IN : line input handshake; IN_FIRST marks
//                      the first line of a frame (replicated PAD_TOP extra times)
//   OUT_VALID/OUT_READY/DATA_OUT       : window output; slot 0 (oldest) at LSBs
//   LINE_COUNT       : valid lines currently held, 0..DEPTH
module reg_input_window
  import reg_input_window_pkg::*;
#(
  parameter  int unsigned PIX_W   = PIX_W_DEF,
  parameter  int unsigned PIXELS  = PIXELS_DEF,
  parameter  int unsigned DEPTH   = DEPTH_DEF,
  parameter  int unsigned PAD_TOP = PAD_TOP_DEF,
  localparam int unsigned LINE_W  = line_width(PIX_W, PIXELS),
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                    CLK,
  input  logic                    RST_ASYNC_N,
  input  logic                    CLEAR,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic                    IN_FIRST,
  input  logic [LINE_W-1:0]       DATA_IN,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [DEPTH*LINE_W-1:0] DATA_OUT,
  output logic [CNT_W-1:0]        LINE_COUNT
);

  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $error("reg_input_window: DEPTH must be in 2..16");
  end
  if (PAD_TOP > DEPTH - 1) begin : g_bad_pad
    $error("reg_input_window: PAD_TOP must be in 0..DEPTH-1");
  end

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(PAD_TOP + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              acc_in, acc_out, load_first, shift;
  logic [LINE_W-1:0] slot_q [DEPTH];
  logic [LINE_W-1:0] slot_d [DEPTH];
  logic [DEPTH-1:0]  slot_en;

  assign IN_READY = !out_valid_q || OUT_READY;

  // CLEAR masks both handshakes so a same-cycle transfer is dropped.
  assign acc_in     = IN_VALID && IN_READY && !CLEAR;
  assign acc_out    = out_valid_q && OUT_READY && !CLEAR;
  assign load_first = acc_in && IN_FIRST;
  assign shift      = acc_in && !IN_FIRST;

  // Simultaneous accept and consume: shift in, drop oldest, count stays full.
  always_comb begin
    cnt_d = cnt_q;
    if (CLEAR) begin
      cnt_d = '0;
    end else if (load_first) begin
      cnt_d = CNT_FIRST;
    end else if (acc_in && !acc_out) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (acc_out && !acc_in) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    out_valid_d = (cnt_d == CNT_FULL);
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign OUT_VALID  = out_valid_q;
  assign LINE_COUNT = cnt_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    // Top PAD_TOP+1 slots receive the first-of-frame line; lower ones keep stale data.
    localparam logic IS_PAD = (i >= int'(DEPTH - 1 - PAD_TOP));

    if (i == DEPTH - 1) begin : g_top
      assign slot_d[i] = DATA_IN;
    end else begin : g_mid
      assign slot_d[i] = load_first ? DATA_IN : slot_q[i+1];
    end

    assign slot_en[i] = shift || (load_first && IS_PAD);

    reg_line_slot #(
      .LINE_W (LINE_W)
    ) u_slot (
      .clk_i   (CLK),
      .rst_ni  (RST_ASYNC_N),
      .clear_i (CLEAR),
      .en_i    (slot_en[i]),
      .d_i     (slot_d[i]),
      .q_o     (slot_q[i])
    );

    assign DATA_OUT[slot_lsb(i, LINE_W) +: LINE_W] = slot_q[i];
  end

endmodule

// File: tb/tb_reg_input_window.sv
// Self-checking bench for reg_input_window: three configurations
// (defaults with PAD_TOP=1, defaults with PAD_TOP=3, PIX_W=10/PIXELS=4/DEPTH=2).
module tb_reg_input_window;

  logic CLK = 1'b0;
  logic rst_n;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUT A: defaults, PAD_TOP=1 ----------------
  logic         a_clear, a_iv, a_ir, a_if, a_ov, a_or;
  logic [71:0]  a_din;
  logic [287:0] a_dout;
  logic [2:0]   a_cnt;

  reg_input_window #(.PIX_W(8), .PIXELS(9), .DEPTH(4), .PAD_TOP(1)) u_a (
    .CLK(CLK), .RST_ASYNC_N(rst_n), .CLEAR(a_clear), .IN_VALID(a_iv),
    .IN_READY(a_ir), .IN_FIRST(a_if), .DATA_IN(a_din), .OUT_VALID(a_ov),
    .OUT_READY(a_or), .DATA_OUT(a_dout), .LINE_COUNT(a_cnt));

  // ---------------- DUT B: defaults, PAD_TOP=3 ----------------
  logic         b_clear, b_iv, b_ir, b_if, b_ov, b_or;
  logic [71:0]  b_din;
  logic [287:0] b_dout;
  logic [2:0]   b_cnt;

  reg_input_window #(.PIX_W(8), .PIXELS(9), .DEPTH(4), .PAD_TOP(3)) u_b (
    .CLK(CLK), .RST_ASYNC_N(rst_n), .CLEAR(b_clear), .IN_VALID(b_iv),
    .IN_READY(b_ir), .IN_FIRST(b_if), .DATA_IN(b_din), .OUT_VALID(b_ov),
    .OUT_READY(b_or), .DATA_OUT(b_dout), .LINE_COUNT(b_cnt));

  // ---------------- DUT C: PIX_W=10, PIXELS=4, DEPTH=2 ----------------
  logic         c_clear, c_iv, c_ir, c_if, c_ov, c_or;
  logic [39:0]  c_din;
  logic [79:0]  c_dout;
  logic [1:0]   c_cnt;

  reg_input_window #(.PIX_W(10), .PIXELS(4), .DEPTH(2), .PAD_TOP(1)) u_c (
    .CLK(CLK), .RST_ASYNC_N(rst_n), .CLEAR(c_clear), .IN_VALID(c_iv),
    .IN_READY(c_ir), .IN_FIRST(c_if), .DATA_IN(c_din), .OUT_VALID(c_ov),
    .OUT_READY(c_or), .DATA_OUT(c_dout), .LINE_COUNT(c_cnt));

  task automatic check(input string nm, input logic [287:0] act, input logic [287:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [71:0] rep8(input logic [7:0] v);
    return {9{v}};
  endfunction

  // ---------------- Reference model for DUT A ----------------
  // Window modelled as a queue of the valid lines, oldest first.
  // The newest valid line always sits in the top slot.
  logic [71:0] mq[$];
  logic m_full, m_ir, m_ain, m_aout;

  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      m_full = (mq.size() == 4);
      m_ir   = !m_full || a_or;
      m_ain  = a_iv && m_ir;
      m_aout = m_full && a_or;
      if (a_clear) begin
        mq.delete();
      end else if (m_ain && a_if) begin
        mq.delete();
        repeat (2) mq.push_back(a_din);
      end else begin
        if (m_aout) void'(mq.pop_front());
        if (m_ain) mq.push_back(a_din);
      end
    end
  end

  always @(negedge CLK) begin
    if (rst_n) begin
      check("A_count", 288'(a_cnt), 288'(mq.size()));
      check("A_out_valid", 288'(a_ov), 288'(mq.size() == 4));
      check("A_in_ready", 288'(a_ir), 288'((mq.size() != 4) || a_or));
      for (int j = 0; j < mq.size(); j++)
        check("A_slot", 288'(a_dout[(3 - j) * 72 +: 72]), 288'(mq[mq.size() - 1 - j]));
    end
  end

  task automatic step_a(input logic v, input logic f, input logic r, input logic c,
                        input logic [71:0] d);
    a_iv = v; a_if = f; a_or = r; a_clear = c; a_din = d;
    @(posedge CLK); #1;
    a_iv = 1'b0; a_if = 1'b0; a_clear = 1'b0;
  endtask

  initial begin
    logic [287:0] saved;
    rst_n = 1'b0;
    a_clear = 0; a_iv = 0; a_if = 0; a_or = 0; a_din = '0;
    b_clear = 0; b_iv = 0; b_if = 0; b_or = 0; b_din = '0;
    c_clear = 0; c_iv = 0; c_if = 0; c_or = 0; c_din = '0;
    #12;
    check("rst_A_count", 288'(a_cnt), 288'(0));
    check("rst_A_valid", 288'(a_ov), 288'(0));
    check("rst_A_ready", 288'(a_ir), 288'(1));
    check("rst_A_data", a_dout, 288'(0));
    rst_n = 1'b1;
    @(posedge CLK); #1;

    // ---- B: PAD_TOP=3, one first-of-frame line fills the window ----
    b_iv = 1; b_if = 1; b_din = rep8(8'h33);
    @(posedge CLK); #1;
    b_iv = 0; b_if = 0;
    check("B_valid", 288'(b_ov), 288'(1));
    check("B_count", 288'(b_cnt), 288'(4));
    check("B_data", b_dout, {4{rep8(8'h33)}});
    check("B_ready", 288'(b_ir), 288'(0));

    // ---- C: small geometry fill ----
    c_or = 0;
    for (int k = 1; k <= 3; k++) begin
      c_iv = 1; c_din = {4{10'(k)}};
      @(posedge CLK); #1;
      c_iv = 0;
      if (k <= 2) check("C_count", 288'(c_cnt), 288'(k));
      else        check("C_count_hold", 288'(c_cnt), 288'(2));
    end
    check("C_valid", 288'(c_ov), 288'(1));
    check("C_ready", 288'(c_ir), 288'(0));
    check("C_slot0", 288'(c_dout[39:0]), 288'(40'h0040100401));
    check("C_slot1", 288'(c_dout[79:40]), 288'(40'h0080200802));

    // ---- A: fill ----
    for (int k = 1; k <= 4; k++) begin
      step_a(1, 0, 0, 0, rep8(8'(k)));
      check("A_fill_count", 288'(a_cnt), 288'(k));
    end
    check("A_fill_valid", 288'(a_ov), 288'(1));
    check("A_fill_slot0", 288'(a_dout[71:0]), 288'(72'h010101010101010101));
    check("A_fill_slot3", 288'(a_dout[287:216]), 288'(72'h040404040404040404));
    check("A_fill_ready", 288'(a_ir), 288'(0));
    saved = a_dout;
    step_a(1, 0, 0, 0, rep8(8'h05));
    check("A_stall_count", 288'(a_cnt), 288'(4));
    check("A_stall_data", a_dout, saved);

    // ---- A: streaming ----
    for (int k = 5; k <= 7; k++) begin
      step_a(1, 0, 1, 0, rep8(8'(k)));
      check("A_stream_valid", 288'(a_ov), 288'(1));
      check("A_stream_count", 288'(a_cnt), 288'(4));
    end
    check("A_stream_win", a_dout, {rep8(8'h07), rep8(8'h06), rep8(8'h05), rep8(8'h04)});

    // ---- A: drain one without input ----
    step_a(0, 0, 1, 0, '0);
    a_or = 0; #1;
    check("A_drain_count", 288'(a_cnt), 288'(3));
    check("A_drain_valid", 288'(a_ov), 288'(0));
    check("A_drain_ready", 288'(a_ir), 288'(1));

    // ---- A: first-of-frame with PAD_TOP=1 ----
    step_a(1, 1, 0, 0, rep8(8'hAA));
    check("A_first_count", 288'(a_cnt), 288'(2));
    check("A_first_top", 288'(a_dout[287:144]), 288'({rep8(8'hAA), rep8(8'hAA)}));
    step_a(1, 0, 0, 0, rep8(8'h01));
    step_a(1, 0, 0, 0, rep8(8'h02));
    check("A_first_valid", 288'(a_ov), 288'(1));
    check("A_first_win", a_dout, {rep8(8'h02), rep8(8'h01), rep8(8'hAA), rep8(8'hAA)});

    // ---- A: first-of-frame while consuming, then CLEAR against traffic ----
    step_a(1, 1, 1, 0, rep8(8'hAA));
    check("A_first_consume_count", 288'(a_cnt), 288'(2));
    step_a(1, 0, 0, 1, rep8(8'h55));
    check("A_clear_count", 288'(a_cnt), 288'(0));
    check("A_clear_valid", 288'(a_ov), 288'(0));
    check("A_clear_data", a_dout, 288'(0));

    // ---- A: async reset mid-fill ----
    for (int k = 1; k <= 3; k++) step_a(1, 0, 0, 0, rep8(8'(k + 8'h10)));
    check("A_prereset_count", 288'(a_cnt), 288'(3));
    #1 rst_n = 1'b0;
    #1;
    check("A_async_count", 288'(a_cnt), 288'(0));
    check("A_async_valid", 288'(a_ov), 288'(0));
    check("A_async_data", a_dout, 288'(0));
    check("A_async_ready", 288'(a_ir), 288'(1));
    #1 rst_n = 1'b1;

    // ---- A: randomized traffic against the model ----
    for (int n = 0; n < 500; n++) begin
      step_a(($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 3) != 0,
             ($urandom % 40) == 0, {8'($urandom), $urandom, $urandom});
    end
    a_or = 0;
    @(posedge CLK); #1;
    @(negedge CLK); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
